// File: rtl/trig_capture_ctrl.sv
// trig_capture_ctrl: trigger evaluation on the live stream, linear capture of the delayed stream,
// registered host readback. Rev 1.0
`default_nettype none

module trig_capture_ctrl #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4096,
  parameter int ADR_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] live_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [WIDTH-1:0] trig_val_i,
  input  logic [WIDTH-1:0] trig_mask_i,
  input  logic             trig_edge_i,
  input  logic [15:0]      capt_len_i,
  input  logic             arm_i,
  input  logic             abort_i,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic [15:0]      capt_cnt_o,
  input  logic             rd_en_i,
  input  logic [ADR_W-1:0] rd_adr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state_q;
  logic [15:0]       cnt_q;
  logic [15:0]       eff_len_q;
  logic              prev_match_q;
  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_valid_q;
  logic              done_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              match;
  logic              fire;
  logic              wr_en;
  logic              rd_ok;
  logic [15:0]       eff_len_d;

  assign match     = (((live_i ^ trig_val_i) & trig_mask_i) == '0);
  assign fire      = ce_i && (state_q == ARMED) && (trig_edge_i ? (match && !prev_match_q) : match);
  assign wr_en     = !abort_i && ce_i && (fire || (state_q == CAPT));
  assign rd_ok     = (state_q == IDLE) || (state_q == DONE);
  assign eff_len_d = ((capt_len_i == 16'd0) || ({1'b0, capt_len_i} > DEPTH_L)) ?
                     DEPTH_L[15:0] : capt_len_i;

  // Write address is the running count; it is 0 throughout ARMED and never exceeds eff_len-1.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[cnt_q[ADR_W-1:0]] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      cnt_q        <= 16'd0;
      eff_len_q    <= DEPTH_L[15:0];
      prev_match_q <= 1'b1;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i && rd_ok;
      if (rd_en_i && rd_ok) rd_data_q <= mem[rd_adr_i];

      if (abort_i) begin
        state_q <= IDLE;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (arm_i) begin
              state_q      <= ARMED;
              done_q       <= 1'b0;
              cnt_q        <= 16'd0;
              prev_match_q <= 1'b1;
              eff_len_q    <= eff_len_d;
            end
          end
          ARMED: begin
            if (ce_i) prev_match_q <= match;
            if (fire) begin
              cnt_q <= 16'd1;
              if (eff_len_q == 16'd1) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= CAPT;
              end
            end
          end
          CAPT: begin
            if (ce_i) begin
              cnt_q <= cnt_q + 16'd1;
              if (cnt_q + 16'd1 == eff_len_q) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign state_o    = state_q;
  assign done_o     = done_q;
  assign capt_cnt_o = cnt_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

`default_nettype wire
